// File: rtl/delay_arbiter_pkg.sv
// Shared defaults and types for the two-requester delay-unit arbiter.
package delay_arbiter_pkg;

  localparam int unsigned WIDTH_DEFAULT = 5;
  localparam int unsigned DEPTH_DEFAULT = 4;

  // Requester index carried through the tag FIFO
  typedef logic tag_t;
  typedef logic [WIDTH_DEFAULT-1:0] data_t;

endpackage

// File: rtl/delay_tag_fifo.sv
// In-order FIFO of requester tags, one entry per transfer outstanding in the delay unit.
module delay_tag_fifo
  import delay_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  tag_t i_tag,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output tag_t o_head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  tag_t            r_mem [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [PtrW:0]   r_cnt;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_cnt == FullCnt);
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];

  // Full blocks push even when a pop lands in the same cycle
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Tag storage needs no reset: the head is only consumed when not empty
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_tag;
  end

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin sharing of one in-order delay unit between two requesters, with
// responses routed back by a tag FIFO.
module delay_arbiter
  import delay_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] REQ_0_data,
  input  logic [WIDTH-1:0] REQ_1_data,
  input  logic             REQ_0_valid,
  input  logic             REQ_1_valid,
  output logic             REQ_0_ready,
  output logic             REQ_1_ready,
  output logic [WIDTH-1:0] DU_IN_data,
  output logic             DU_IN_valid,
  input  logic             DU_IN_ready,
  input  logic [WIDTH-1:0] DU_OUT_data,
  input  logic             DU_OUT_valid,
  output logic             DU_OUT_ready,
  output logic [WIDTH-1:0] RSP_0_data,
  output logic [WIDTH-1:0] RSP_1_data,
  output logic             RSP_0_valid,
  output logic             RSP_1_valid,
  input  logic             RSP_0_ready,
  input  logic             RSP_1_ready,
  output logic             ERR
);

  tag_t r_rr;
  tag_t r_lock_gnt;
  logic r_lock;
  logic r_err;

  tag_t w_gnt;
  tag_t w_head;
  logic w_full;
  logic w_empty;
  logic w_gnt_valid;
  logic w_du_in_valid;
  logic w_du_out_ready;
  logic w_issue;
  logic w_pop;

  // A lone valid requester wins outright; a tie goes to the round-robin pointer
  always_comb begin
    w_gnt = r_rr;
    if (r_lock) begin
      w_gnt = r_lock_gnt;
    end else if (REQ_0_valid && REQ_1_valid) begin
      w_gnt = r_rr;
    end else if (REQ_0_valid) begin
      w_gnt = 1'b0;
    end else if (REQ_1_valid) begin
      w_gnt = 1'b1;
    end
  end

  assign w_gnt_valid   = w_gnt ? REQ_1_valid : REQ_0_valid;
  // Reset gating keeps every handshake output low while the FIFO is held empty
  assign w_du_in_valid = w_gnt_valid & ~w_full & ASYNCRESETN;
  assign w_issue       = w_du_in_valid & DU_IN_ready;

  assign DU_IN_valid = w_du_in_valid;
  assign DU_IN_data  = w_gnt ? REQ_1_data : REQ_0_data;
  assign REQ_0_ready = DU_IN_ready & ~w_gnt & ~w_full & ASYNCRESETN;
  assign REQ_1_ready = DU_IN_ready & w_gnt & ~w_full & ASYNCRESETN;

  assign w_du_out_ready = ~w_empty & (w_head ? RSP_1_ready : RSP_0_ready);
  assign w_pop          = w_du_out_ready & DU_OUT_valid;

  assign DU_OUT_ready = w_du_out_ready;
  assign RSP_0_data   = DU_OUT_data;
  assign RSP_1_data   = DU_OUT_data;
  assign RSP_0_valid  = DU_OUT_valid & ~w_empty & ~w_head;
  assign RSP_1_valid  = DU_OUT_valid & ~w_empty & w_head;
  assign ERR          = r_err;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_rr       <= 1'b0;
      r_lock     <= 1'b0;
      r_lock_gnt <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_issue) r_rr <= ~w_gnt;
      // Hold the grant while an offered transfer waits for the delay unit
      r_lock     <= w_du_in_valid & ~DU_IN_ready;
      r_lock_gnt <= w_gnt;
      if (DU_OUT_valid && w_empty) r_err <= 1'b1;
    end
  end

  delay_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .i_clk   (CLK),
    .i_rst_n (ASYNCRESETN),
    .i_push  (w_issue),
    .i_tag   (w_gnt),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule

// File: tb/tb_delay_arbiter.sv
// Randomized and directed bench for delay_arbiter against a transaction-level model.
module tb_delay_arbiter;

  localparam int unsigned W = 5;
  localparam int unsigned D = 4;

  typedef struct {
    logic [W-1:0] d;
    int           rdy;
  } du_item_t;

  logic         CLK = 1'b0;
  logic         ASYNCRESETN;
  logic [W-1:0] REQ_0_data, REQ_1_data, DU_IN_data, DU_OUT_data, RSP_0_data, RSP_1_data;
  logic         REQ_0_valid, REQ_1_valid, REQ_0_ready, REQ_1_ready;
  logic         DU_IN_valid, DU_IN_ready, DU_OUT_valid, DU_OUT_ready;
  logic         RSP_0_valid, RSP_1_valid, RSP_0_ready, RSP_1_ready, ERR;

  delay_arbiter #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .CLK          (CLK),
    .ASYNCRESETN  (ASYNCRESETN),
    .REQ_0_data   (REQ_0_data),
    .REQ_1_data   (REQ_1_data),
    .REQ_0_valid  (REQ_0_valid),
    .REQ_1_valid  (REQ_1_valid),
    .REQ_0_ready  (REQ_0_ready),
    .REQ_1_ready  (REQ_1_ready),
    .DU_IN_data   (DU_IN_data),
    .DU_IN_valid  (DU_IN_valid),
    .DU_IN_ready  (DU_IN_ready),
    .DU_OUT_data  (DU_OUT_data),
    .DU_OUT_valid (DU_OUT_valid),
    .DU_OUT_ready (DU_OUT_ready),
    .RSP_0_data   (RSP_0_data),
    .RSP_1_data   (RSP_1_data),
    .RSP_0_valid  (RSP_0_valid),
    .RSP_1_valid  (RSP_1_valid),
    .RSP_0_ready  (RSP_0_ready),
    .RSP_1_ready  (RSP_1_ready),
    .ERR          (ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec, n_bad, cyc, cyc0;

  // Stimulus knobs
  int           offer [2];
  int unsigned  vpct, du_pct, rsp_pct;
  int           lat;
  bit           incr, inj;
  logic [W-1:0] base [2];

  // Requesters and delay unit environment
  bit           hold [2];
  logic [W-1:0] rd [2];
  int           sent [2];
  du_item_t     duq [$];

  // Reference model: outstanding owners, expected payloads, arbitration state
  bit           tags [$];
  logic [W-1:0] pay0 [$];
  logic [W-1:0] pay1 [$];
  bit           pref, lock, lock_g, err_m;

  // DUT-side observations
  int ilog [$];
  int rsp_cnt [2];
  int first_rsp0, first_issue;
  bit rsp1_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc - cyc0);
    end
  endtask

  task automatic step();
    bit           g, full, empty, t, ev, eready;
    bit           h_in, h_out, h_r0, h_r1;
    bit [1:0]     v, ereq, ersp;
    logic [W-1:0] cap_d, ed;
    du_item_t     it;
    for (int n = 0; n < 2; n++) begin
      if (!hold[n] && offer[n] > 0 && $urandom_range(0, 99) < vpct) begin
        hold[n] = 1'b1;
        offer[n]--;
        rd[n] = incr ? W'(int'(base[n]) + sent[n]) : W'($urandom);
      end
    end
    REQ_0_valid  = hold[0];
    REQ_0_data   = rd[0];
    REQ_1_valid  = hold[1];
    REQ_1_data   = rd[1];
    DU_IN_ready  = $urandom_range(0, 99) < du_pct;
    RSP_0_ready  = $urandom_range(0, 99) < rsp_pct;
    RSP_1_ready  = $urandom_range(0, 99) < rsp_pct;
    DU_OUT_data  = W'($urandom);
    DU_OUT_valid = 1'b0;
    if (inj) begin
      DU_OUT_valid = 1'b1;
    end else if (duq.size() > 0 && cyc >= duq[0].rdy) begin
      DU_OUT_valid = 1'b1;
      DU_OUT_data  = duq[0].d;
    end
    #1;
    v     = {hold[1], hold[0]};
    full  = tags.size() == D;
    empty = tags.size() == 0;
    if (lock)            g = lock_g;
    else if (v == 2'b11) g = pref;
    else if (v[0])       g = 1'b0;
    else if (v[1])       g = 1'b1;
    else                 g = pref;
    ev   = v[g] && !full;
    ereq = 2'b00;
    if (DU_IN_ready && !full) ereq[g] = 1'b1;
    t    = empty ? 1'b0 : tags[0];
    ersp = 2'b00;
    if (!empty && DU_OUT_valid) ersp[t] = 1'b1;
    eready = !empty && (t ? RSP_1_ready : RSP_0_ready);
    check_eq("du_in_valid", 32'(DU_IN_valid), 32'(ev));
    if (ev) check_eq("du_in_data", 32'(DU_IN_data), 32'(g ? rd[1] : rd[0]));
    check_eq("req_ready", 32'({REQ_1_ready, REQ_0_ready}), 32'(ereq));
    check_eq("rsp_valid", 32'({RSP_1_valid, RSP_0_valid}), 32'(ersp));
    check_eq("du_out_ready", 32'(DU_OUT_ready), 32'(eready));
    check_eq("err", 32'(ERR), 32'(err_m));
    if (ersp != 2'b00 && eready) begin
      if (t) ed = pay1.pop_front();
      else   ed = pay0.pop_front();
      check_eq("rsp_payload", 32'(t ? RSP_1_data : RSP_0_data), 32'(ed));
    end
    h_in  = DU_IN_valid && DU_IN_ready;
    h_out = DU_OUT_valid && DU_OUT_ready;
    h_r0  = REQ_0_valid && REQ_0_ready;
    h_r1  = REQ_1_valid && REQ_1_ready;
    cap_d = DU_IN_data;
    if (RSP_0_valid && first_rsp0 < 0) first_rsp0 = cyc - cyc0;
    if (RSP_1_valid) rsp1_seen = 1'b1;
    if (RSP_0_valid && RSP_0_ready) rsp_cnt[0]++;
    if (RSP_1_valid && RSP_1_ready) rsp_cnt[1]++;
    @(posedge CLK);
    if (eready && DU_OUT_valid) void'(tags.pop_front());
    if (ev && DU_IN_ready) begin
      tags.push_back(g);
      if (g) pay1.push_back(rd[1]);
      else   pay0.push_back(rd[0]);
      pref = !g;
    end
    if (DU_OUT_valid && empty) err_m = 1'b1;
    lock   = ev && !DU_IN_ready;
    lock_g = g;
    if (h_out && duq.size() > 0) void'(duq.pop_front());
    if (h_in) begin
      it.d   = cap_d;
      it.rdy = cyc + ((lat > 0) ? lat : int'($urandom_range(1, 4)));
      duq.push_back(it);
    end
    if (h_r0) begin
      hold[0] = 1'b0;
      sent[0]++;
      ilog.push_back(0);
    end
    if (h_r1) begin
      hold[1] = 1'b0;
      sent[1]++;
      ilog.push_back(1);
    end
    if ((h_r0 || h_r1) && first_issue < 0) first_issue = cyc - cyc0;
    cyc++;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    ASYNCRESETN = 1'b0;
    #1;
    check_eq("reset_outputs",
             32'({DU_IN_valid, REQ_0_ready, REQ_1_ready, RSP_0_valid, RSP_1_valid,
                  DU_OUT_ready, ERR}), 32'd0);
    repeat (2) @(negedge CLK);
    ASYNCRESETN = 1'b1;
    tags.delete();
    pay0.delete();
    pay1.delete();
    duq.delete();
    ilog.delete();
    hold        = '{1'b0, 1'b0};
    sent        = '{0, 0};
    rsp_cnt     = '{0, 0};
    offer       = '{0, 0};
    pref        = 1'b0;
    lock        = 1'b0;
    lock_g      = 1'b0;
    err_m       = 1'b0;
    inj         = 1'b0;
    first_rsp0  = -1;
    first_issue = -1;
    rsp1_seen   = 1'b0;
    cyc0        = cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, want finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order;
    int guard;
    n_vec = 0;
    n_bad = 0;
    cyc   = 0;
    cyc0  = 0;
    ASYNCRESETN  = 1'b0;
    REQ_0_data   = '0;
    REQ_1_data   = '0;
    REQ_0_valid  = 1'b0;
    REQ_1_valid  = 1'b0;
    DU_IN_ready  = 1'b0;
    DU_OUT_data  = '0;
    DU_OUT_valid = 1'b0;
    RSP_0_ready  = 1'b0;
    RSP_1_ready  = 1'b0;
    vpct    = 100;
    du_pct  = 100;
    rsp_pct = 100;
    lat     = 3;
    incr    = 1'b1;
    base    = '{5'h0A, 5'h00};
    @(negedge CLK);

    // Single requester through a 3-cycle delay unit
    do_reset();
    offer = '{1, 0};
    repeat (6) step();
    check_eq("s1_first_issue", 32'(first_issue), 32'd0);
    check_eq("s1_rsp0_cycle", 32'(first_rsp0), 32'd3);
    check_eq("s1_rsp1_quiet", 32'(rsp1_seen), 32'd0);

    // Both requesters continuously valid
    do_reset();
    offer = '{4, 4};
    base  = '{5'h01, 5'h11};
    lat   = 2;
    repeat (14) step();
    order = 0;
    for (int i = 0; i < 4 && i < ilog.size(); i++) order = order * 10 + ilog[i] + 1;
    check_eq("s2_issue_count", 32'(ilog.size()), 32'd8);
    check_eq("s2_issue_order", 32'(order), 32'd1212);
    check_eq("s2_rsp0_count", 32'(rsp_cnt[0]), 32'd4);
    check_eq("s2_rsp1_count", 32'(rsp_cnt[1]), 32'd4);

    // Delay unit back-pressure for 4 cycles
    do_reset();
    offer  = '{2, 2};
    du_pct = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("s3_stall_data", 32'(DU_IN_data), 32'h01);
      check_eq("s3_stall_ready", 32'({REQ_1_ready, REQ_0_ready}), 32'd0);
    end
    check_eq("s3_no_issue", 32'(ilog.size()), 32'd0);
    du_pct = 100;
    step();
    check_eq("s3_one_issue", 32'(ilog.size()), 32'd1);
    repeat (12) step();

    // Tag FIFO full: a pop does not free a slot in the same cycle
    do_reset();
    offer   = '{3, 3};
    rsp_pct = 0;
    lat     = 1;
    repeat (6) step();
    check_eq("s4_outstanding", 32'(ilog.size()), 32'd4);
    check_eq("s4_full_stall", 32'({DU_IN_valid, REQ_1_ready, REQ_0_ready}), 32'd0);
    rsp_pct = 100;
    step();
    check_eq("s4_no_same_cycle_issue", 32'(ilog.size()), 32'd4);
    rsp_pct = 0;
    step();
    check_eq("s4_issue_after_pop", 32'(ilog.size()), 32'd5);
    rsp_pct = 100;
    repeat (12) step();

    // Spurious result with nothing outstanding
    do_reset();
    inj = 1'b1;
    step();
    inj = 1'b0;
    check_eq("s5_err_set", 32'(ERR), 32'd1);
    repeat (3) step();
    check_eq("s5_err_sticky", 32'(ERR), 32'd1);
    ASYNCRESETN = 1'b0;
    #1;
    check_eq("s5_err_async_clear", 32'(ERR), 32'd0);

    // Reset with transfers outstanding
    do_reset();
    offer   = '{2, 2};
    rsp_pct = 0;
    repeat (3) step();
    check_eq("s6_outstanding", 32'(ilog.size()), 32'd3);
    do_reset();
    offer   = '{1, 1};
    rsp_pct = 100;
    step();
    check_eq("s6_first_after_reset", 32'((ilog.size() > 0) ? ilog[0] : 9), 32'd0);
    repeat (6) step();

    // Randomized traffic with variable delay-unit latency
    do_reset();
    offer   = '{60, 60};
    incr    = 1'b0;
    vpct    = 60;
    du_pct  = 70;
    rsp_pct = 70;
    lat     = 0;
    guard   = 0;
    while ((offer[0] + offer[1] > 0 || hold[0] || hold[1] || duq.size() > 0) && guard < 2000) begin
      step();
      guard++;
    end
    check_eq("rand_drained", 32'(guard < 2000), 32'd1);
    check_eq("rand_rsp_total", 32'(rsp_cnt[0] + rsp_cnt[1]), 32'd120);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/delay_arbiter.md
DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, as the data width of every channel.
REQ-002 The block SHALL have parameter DEPTH, default 4, as the maximum number of outstanding transfers; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have these ports:
- CLK  in  1  single clock, rising edge.
- ASYNCRESETN  in  1  reset, asynchronous assert, active-low.
- REQ_0_data, REQ_1_data  in  WIDTH  requester payloads.
- REQ_0_valid, REQ_1_valid  in  1  requester valid.
- REQ_0_ready, REQ_1_ready  out  1  requester ready.
- DU_IN_data  out  WIDTH  payload to the shared delay unit.
- DU_IN_valid  out  1  valid to the shared delay unit.
- DU_IN_ready  in  1  ready from the shared delay unit.
- DU_OUT_data  in  WIDTH  result from the delay unit.
- DU_OUT_valid  in  1  result valid.
- DU_OUT_ready  out  1  result ready.
- RSP_0_data, RSP_1_data  out  WIDTH  per-requester responses.
- RSP_0_valid, RSP_1_valid  out  1  response valid.
- RSP_0_ready, RSP_1_ready  in  1  response ready.
- ERR  out  1  sticky protocol-error flag.

Function
REQ-004 The block SHALL share one in-order delay unit between two ready/valid requesters and route each result back to the requester that issued it.
REQ-005 A handshake SHALL occur on a channel only in a cycle where both valid and ready are high at the rising edge of CLK.
REQ-006 Arbitration SHALL be round-robin: when both requesters are valid and no grant is locked, the requester not served by the last issue handshake wins; after reset, requester 0 wins.
REQ-007 Once DU_IN_valid is high without a handshake, the grant SHALL be locked until the handshake, so DU_IN_data and DU_IN_valid stay stable.
REQ-008 DU_IN_data SHALL equal the granted REQ_n_data, and DU_IN_valid SHALL equal the granted REQ_n_valid AND not-full, with zero-cycle combinational latency.
REQ-009 REQ_n_ready SHALL equal DU_IN_ready AND granted(n) AND not-full; the non-granted requester's ready SHALL be low.
REQ-010 On each issue handshake the requester index SHALL be pushed into a DEPTH-entry tag FIFO.
REQ-011 When the tag FIFO is full (DEPTH outstanding):
- DU_IN_valid and both REQ_n_ready SHALL be low.
- In the same cycle, a pop SHALL NOT free a slot for an issue.
REQ-012 Response routing SHALL use the FIFO head tag t, with zero-cycle combinational routing:
- RSP_t_data SHALL equal DU_OUT_data.
- RSP_t_valid SHALL equal DU_OUT_valid AND not-empty.
- The other RSP_valid SHALL be low.
- DU_OUT_ready SHALL equal RSP_t_ready AND not-empty.
REQ-013 A handshake on DU_OUT SHALL pop the tag FIFO.
REQ-014 When push and pop occur in the same cycle and the FIFO is not full, the occupancy count SHALL be unchanged and both pointers SHALL advance.
REQ-015 The FIFO read and write pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-016 If DU_OUT_valid is high while the FIFO is empty, ERR SHALL set on that edge and hold until reset.
REQ-017 While the FIFO is empty, DU_OUT_ready SHALL be low and no RSP_valid SHALL be asserted.

Reset
REQ-018 While ASYNCRESETN is low, the following SHALL hold regardless of CLK:
- The FIFO SHALL be empty with both pointers 0.
- The round-robin pointer SHALL select requester 0.
- The lock SHALL be clear and ERR SHALL be 0.
REQ-019 During reset all ready and valid outputs SHALL be 0; data outputs follow REQ-008/REQ-012.
REQ-020 Reset mid-operation SHALL discard all outstanding tags; the delay unit SHALL be reset in the same domain.

Structure
REQ-021 Package delay_arbiter_pkg SHALL hold WIDTH_DEFAULT=5, DEPTH_DEFAULT=4, typedef tag_t (1 bit, requester index) and typedef data_t.
REQ-022 The tag FIFO SHALL be a sub-module delay_tag_fifo (push, pop, full, empty, head); the arbitration and routing logic SHALL stay in delay_arbiter.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset: REQ_0 valid only, data 5'h0A, DU_IN_ready=1, delay unit 3-cycle → DU_IN_data=0A at cycle 0; RSP_0 valid with 0A at cycle 3; RSP_1_valid stays 0.
- Both requesters valid continuously (REQ_0=5'h01.., REQ_1=5'h11..), all readies 1 → issue order 0,1,0,1; each response arrives on the originating RSP port in order.
- DU_IN_ready held 0 for 4 cycles with both requesters valid → DU_IN_data stable, grant unchanged, no REQ_ready high; on release exactly one handshake occurs.
- RSP ports held not-ready until 4 transfers are outstanding → 5th request stalls (REQ_ready=0); one response pop allows an issue on the next cycle, not the same one.
- DU_OUT_valid=1 with the FIFO empty → ERR=1 next edge and stays 1; ASYNCRESETN low clears ERR immediately.
- ASYNCRESETN pulsed low with 3 outstanding → all outputs 0 during reset; after release the FIFO is empty and requester 0 has priority.
